// File: rtl/io_bus_sequencer.sv
// Purpose: qualifies Z80 IO cycles to this board's port window and drives the chip-select decoder, wait line and device strobes.
// Latency: claim registered 2 clks after IORQ/strobe are first sampled low; release 2-3 clks after IORQ rises.
// Backpressure: stalls the CPU with cpu_wait_n for WAIT_CYCLES+1 clks per claimed cycle; no stall on ignored cycles.
module io_bus_sequencer #(
  parameter logic [3:0] BASE_NIBBLE = 4'h8,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_m1_n,
  output logic       cpu_wait_n,
  output logic [3:0] dev_sel,
  output logic       sel_en,
  output logic       io_rd,
  output logic       io_wr,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  // Bit order {iorq, rd, wr, m1}, stored active-high so reset value means "inactive".
  logic [3:0] sync_meta;
  logic [3:0] sync_q;
  logic       s_iorq;
  logic       s_rd;
  logic       s_wr;
  logic       s_m1;
  logic       claim;

  state_t     state;
  logic [3:0] wait_cnt;

  // Two-flop synchronisers for the asynchronous Z80 control strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 4'b0000;
      sync_q    <= 4'b0000;
    end else begin
      sync_meta <= ~{cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n};
      sync_q    <= sync_meta;
    end
  end

  assign s_iorq = sync_q[3];
  assign s_rd   = sync_q[2];
  assign s_wr   = sync_q[1];
  assign s_m1   = sync_q[0];

  // Interrupt acknowledge, ambiguous direction and foreign ports are never claimed.
  // cpu_addr is stable whenever IORQ is low, so it is used unsynchronised.
  assign claim = s_iorq && !s_m1 && (s_rd ^ s_wr) && (cpu_addr[7:4] == BASE_NIBBLE);

  // Cycle sequencer: claim, count wait states, hold selects until IORQ releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      cpu_wait_n <= 1'b1;
      dev_sel    <= 4'd0;
      sel_en     <= 1'b0;
      io_rd      <= 1'b0;
      io_wr      <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          if (claim) begin
            // dev_sel only moves here, while sel_en is low, so the decoder never sees a changing index.
            dev_sel    <= cpu_addr[3:0];
            io_rd      <= s_rd;
            io_wr      <= s_wr;
            sel_en     <= 1'b1;
            cpu_wait_n <= 1'b0;
            wait_cnt   <= WAIT_INIT;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!s_iorq) begin
            // CPU abandoned the cycle: drop everything, no completion pulse.
            sel_en     <= 1'b0;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
            cpu_wait_n <= 1'b1;
            state      <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            cpu_wait_n <= 1'b1;
            cycle_done <= 1'b1;
            state      <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (!s_iorq) begin
            sel_en <= 1'b0;
            io_rd  <= 1'b0;
            io_wr  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Purpose: checks io_bus_sequencer at WAIT_CYCLES 0, 2 and 4 against a transaction-timeline model.
// Latency: model expects claim 2 edges after first low sample and release 2 edges after IORQ rises.
// Backpressure: expects cpu_wait_n low for WAIT_CYCLES+1 clks on claimed cycles only.
module tb_io_bus_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] cpu_addr;
  logic       cpu_iorq_n;
  logic       cpu_rd_n;
  logic       cpu_wr_n;
  logic       cpu_m1_n;

  logic       wait_n0, sel0, rd0, wr0, done0;
  logic       wait_n2, sel2, rd2, wr2, done2;
  logic       wait_n4, sel4, rd4, wr4, done4;
  logic [3:0] dev0, dev2, dev4;

  // Output vector layout: {cpu_wait_n, sel_en, dev_sel[3:0], io_rd, io_wr, cycle_done}
  logic [2:0][8:0] obs;
  logic [8:0]      trace [3][64];
  logic [3:0]      cur_dev;
  int              n_checks;
  int              n_fails;

  localparam logic [8:0] RESET_VEC = 9'b1_0_0000_0_0_0;

  io_bus_sequencer #(.BASE_NIBBLE(4'h8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
    .cpu_wait_n(wait_n0), .dev_sel(dev0), .sel_en(sel0), .io_rd(rd0),
    .io_wr(wr0), .cycle_done(done0)
  );

  io_bus_sequencer #(.BASE_NIBBLE(4'h8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
    .cpu_wait_n(wait_n2), .dev_sel(dev2), .sel_en(sel2), .io_rd(rd2),
    .io_wr(wr2), .cycle_done(done2)
  );

  io_bus_sequencer #(.BASE_NIBBLE(4'h8), .WAIT_CYCLES(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
    .cpu_wait_n(wait_n4), .dev_sel(dev4), .sel_en(sel4), .io_rd(rd4),
    .io_wr(wr4), .cycle_done(done4)
  );

  assign obs[0] = {wait_n0, sel0, dev0, rd0, wr0, done0};
  assign obs[1] = {wait_n2, sel2, dev2, rd2, wr2, done2};
  assign obs[2] = {wait_n4, sel4, dev4, rd4, wr4, done4};

  // Free-running board clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int w_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_claimed(input logic [7:0] addr, input logic rd, input logic wr, input logic m1);
    return (addr[7:4] == 4'h8) && !m1 && (rd != wr);
  endfunction

  // Expected outputs t edges after IORQ/strobe are first sampled low; IORQ first sampled high at edge r.
  // Claim lands at edge 2, wait states end at edge 3+w, IORQ release is seen at edge r+2.
  function automatic logic [8:0] exp_out(input int w, input int t, input bit claimed, input logic rd,
                                         input logic wr, input logic [3:0] dev, input logic [3:0] prev_dev,
                                         input int r);
    int done_edge;
    int rel_edge;
    done_edge = 3 + w;
    rel_edge  = r + 2;
    if (!claimed || t < 2) return {1'b1, 1'b0, prev_dev, 1'b0, 1'b0, 1'b0};
    if (t >= rel_edge)     return {1'b1, 1'b0, dev, 1'b0, 1'b0, 1'b0};
    if (t < done_edge)     return {1'b0, 1'b1, dev, rd, wr, 1'b0};
    if (t == done_edge)    return {1'b1, 1'b1, dev, rd, wr, 1'b1};
    return {1'b1, 1'b1, dev, rd, wr, 1'b0};
  endfunction

  // Drives one bus cycle held low for low_clks edges and records len post-edge samples per DUT.
  task automatic run_txn(input logic [7:0] addr, input logic rd, input logic wr, input logic m1,
                         input int low_clks, input int len);
    @(negedge clk);
    cpu_addr   = addr;
    cpu_iorq_n = 1'b0;
    cpu_rd_n   = ~rd;
    cpu_wr_n   = ~wr;
    cpu_m1_n   = ~m1;
    for (int t = 0; t < len; t++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) trace[d][t] = obs[d];
      if (t == low_clks - 1) begin
        @(negedge clk);
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    cpu_addr   = 8'h00;
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_m1_n   = 1'b1;
    cur_dev    = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (obs[d] !== RESET_VEC) begin
          n_fails++;
          $display("FAIL reset_idle W=%0d clk=%0d got %b expected %b", w_of(d), c, obs[d], RESET_VEC);
        end
      end
    end
  endtask

  task automatic test_read;
    int wait_low;
    int dones;
    run_txn(8'h85, 1'b1, 1'b0, 1'b0, 10, 15);
    for (int t = 0; t < 15; t++) begin
      for (int d = 0; d < 3; d++) begin
        logic [8:0] e;
        e = exp_out(w_of(d), t, 1'b1, 1'b1, 1'b0, 4'h5, cur_dev, 10);
        n_checks++;
        if (trace[d][t] !== e) begin
          n_fails++;
          $display("FAIL read_85 W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t], e);
        end
      end
    end
    cur_dev  = 4'h5;
    wait_low = 0;
    dones    = 0;
    for (int t = 0; t < 15; t++) begin
      if (trace[1][t][8] == 1'b0) wait_low++;
      if (trace[1][t][0] == 1'b1) dones++;
    end
    n_checks++;
    if (wait_low != 3) begin
      n_fails++;
      $display("FAIL read_wait_len got %0d clks expected 3", wait_low);
    end
    n_checks++;
    if (dones != 1) begin
      n_fails++;
      $display("FAIL read_done_count got %0d pulses expected 1", dones);
    end
  endtask

  task automatic test_write;
    run_txn(8'h8F, 1'b0, 1'b1, 1'b0, 9, 14);
    for (int t = 0; t < 14; t++) begin
      for (int d = 0; d < 3; d++) begin
        logic [8:0] e;
        e = exp_out(w_of(d), t, 1'b1, 1'b0, 1'b1, 4'hF, cur_dev, 9);
        n_checks++;
        if (trace[d][t] !== e) begin
          n_fails++;
          $display("FAIL write_8f W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t], e);
        end
      end
    end
    cur_dev = 4'hF;
    run_txn(8'h3F, 1'b0, 1'b1, 1'b0, 8, 12);
    for (int t = 0; t < 12; t++) begin
      for (int d = 0; d < 3; d++) begin
        logic [8:0] e;
        e = exp_out(w_of(d), t, 1'b0, 1'b0, 1'b1, 4'hF, cur_dev, 8);
        n_checks++;
        if (trace[d][t] !== e) begin
          n_fails++;
          $display("FAIL write_3f_ignored W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t], e);
        end
      end
    end
  endtask

  task automatic test_ignored;
    run_txn(8'h80, 1'b1, 1'b0, 1'b1, 8, 12);
    for (int t = 0; t < 12; t++) begin
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (trace[d][t] !== {1'b1, 1'b0, cur_dev, 3'b000}) begin
          n_fails++;
          $display("FAIL intack_ignored W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t],
                   {1'b1, 1'b0, cur_dev, 3'b000});
        end
      end
    end
    run_txn(8'h84, 1'b1, 1'b1, 1'b0, 8, 12);
    for (int t = 0; t < 12; t++) begin
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (trace[d][t] !== {1'b1, 1'b0, cur_dev, 3'b000}) begin
          n_fails++;
          $display("FAIL rd_wr_both_ignored W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t],
                   {1'b1, 1'b0, cur_dev, 3'b000});
        end
      end
    end
  endtask

  // IORQ raised so the FSM sees it one clk into ACTIVE; the W=0 instance has already finished by then.
  task automatic test_abort;
    int dones;
    run_txn(8'h82, 1'b1, 1'b0, 1'b0, 2, 12);
    for (int t = 0; t < 12; t++) begin
      for (int d = 0; d < 3; d++) begin
        logic [8:0] e;
        e = exp_out(w_of(d), t, 1'b1, 1'b1, 1'b0, 4'h2, cur_dev, 2);
        n_checks++;
        if (trace[d][t] !== e) begin
          n_fails++;
          $display("FAIL abort_82 W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t], e);
        end
      end
    end
    cur_dev = 4'h2;
    dones   = 0;
    for (int t = 0; t < 12; t++) if (trace[2][t][0] == 1'b1) dones++;
    n_checks++;
    if (dones != 0) begin
      n_fails++;
      $display("FAIL abort_no_done got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_reset_in_hold;
    @(negedge clk);
    cpu_addr   = 8'h87;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      logic [8:0] e;
      e = exp_out(w_of(d), 9, 1'b1, 1'b0, 1'b1, 4'h7, cur_dev, 100);
      n_checks++;
      if (obs[d] !== e) begin
        n_fails++;
        $display("FAIL hold_before_reset W=%0d got %b expected %b", w_of(d), obs[d], e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (obs[d] !== RESET_VEC) begin
        n_fails++;
        $display("FAIL async_reset W=%0d got %b expected %b", w_of(d), obs[d], RESET_VEC);
      end
    end
    cpu_iorq_n = 1'b1;
    cpu_wr_n   = 1'b1;
    cur_dev    = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h81, 1'b1, 1'b0, 1'b0, 10, 15);
    for (int t = 0; t < 15; t++) begin
      for (int d = 0; d < 3; d++) begin
        logic [8:0] e;
        e = exp_out(w_of(d), t, 1'b1, 1'b1, 1'b0, 4'h1, cur_dev, 10);
        n_checks++;
        if (trace[d][t] !== e) begin
          n_fails++;
          $display("FAIL read_81_after_reset W=%0d t=%0d got %b expected %b", w_of(d), t, trace[d][t], e);
        end
      end
    end
    cur_dev = 4'h1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] addr;
      logic       rd, wr, m1;
      int         kind, low, len;
      bit         cl;
      addr = {($urandom_range(0, 1) == 1) ? 4'h8 : 4'($urandom), 4'($urandom)};
      kind = $urandom_range(0, 5);
      rd   = (kind <= 1) || (kind == 4);
      wr   = (kind == 2) || (kind == 3) || (kind == 4);
      m1   = ($urandom_range(0, 5) == 0);
      low  = $urandom_range(1, 14);
      len  = low + $urandom_range(4, 6);
      cl   = is_claimed(addr, rd, wr, m1);
      run_txn(addr, rd, wr, m1, low, len);
      for (int t = 0; t < len; t++) begin
        for (int d = 0; d < 3; d++) begin
          logic [8:0] e;
          e = exp_out(w_of(d), t, cl, rd, wr, addr[3:0], cur_dev, low);
          n_checks++;
          if (trace[d][t] !== e) begin
            n_fails++;
            $display("FAIL random_%0d addr=%h rd=%b wr=%b m1=%b W=%0d t=%0d got %b expected %b",
                     n, addr, rd, wr, m1, w_of(d), t, trace[d][t], e);
          end
        end
      end
      if (cl) cur_dev = addr[3:0];
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_read();
    test_write();
    test_ignored();
    test_abort();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
